// File: rtl/lcd_pkg.sv
// Shared definitions for the LCD bus arbiter slice.
// Contents:
//   state_t      - arbiter FSM state encoding
//   CMD_CLEAR    - HD44780 "clear display" command byte
//   CMD_HOME     - HD44780 "return home" command byte
//   is_slow_cmd  - true for the commands that need the long post-write wait
package lcd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_PULSE,
    ST_HOLD,
    ST_WAIT
  } state_t;

  localparam logic [7:0] CMD_CLEAR = 8'h01;
  localparam logic [7:0] CMD_HOME  = 8'h02;

  // Clear and home only count as slow when written to the instruction
  // register; the same byte written as data is an ordinary write.
  function automatic logic is_slow_cmd(input logic rs, input logic [7:0] data);
    return (rs == 1'b0) && ((data == CMD_CLEAR) || (data == CMD_HOME));
  endfunction

endpackage

// File: rtl/lcd_bus_arbiter_if.sv
// Requester and LCD pin bundle for lcd_bus_arbiter.
// Signals:
//   req0_valid/rs/data, req0_ready - requester 0 (init sequencer)
//   req1_valid/rs/data, req1_ready - requester 1 (display refresh)
//   done, done_id, busy            - completion and status
//   lcd_e, lcd_rs, lcd_rw, lcd_data- LCD pins
// Modports:
//   slave  - arbiter side
//   master - requester / environment side
interface lcd_bus_arbiter_if;

  logic       req0_valid;
  logic       req0_rs;
  logic [7:0] req0_data;
  logic       req0_ready;
  logic       req1_valid;
  logic       req1_rs;
  logic [7:0] req1_data;
  logic       req1_ready;
  logic       done;
  logic       done_id;
  logic       busy;
  logic       lcd_e;
  logic       lcd_rs;
  logic       lcd_rw;
  logic [7:0] lcd_data;

  modport slave (
    input  req0_valid, req0_rs, req0_data,
    input  req1_valid, req1_rs, req1_data,
    output req0_ready, req1_ready,
    output done, done_id, busy,
    output lcd_e, lcd_rs, lcd_rw, lcd_data
  );

  modport master (
    output req0_valid, req0_rs, req0_data,
    output req1_valid, req1_rs, req1_data,
    input  req0_ready, req1_ready,
    input  done, done_id, busy,
    input  lcd_e, lcd_rs, lcd_rw, lcd_data
  );

endinterface

// File: rtl/lcd_ms_timer.sv
// Millisecond wait timer for the arbiter WAIT state.
// Ports:
//   clk, reset   - clock, asynchronous active-low reset
//   i_load       - restart the timer with i_ms milliseconds
//   i_ms         - wait length in ms (0 behaves as 1)
//   o_expire     - high in the last cycle of the wait
// The tick prescaler restarts on load, so the wait is exactly
// i_ms*CNT1MS cycles with no phase error from a free-running tick.
module lcd_ms_timer #(
  parameter int CNT1MS = 100000,
  parameter int MS_W   = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            i_load,
  input  logic [MS_W-1:0] i_ms,
  output logic            o_expire
);

  localparam int TICK_W = (CNT1MS > 1) ? $clog2(CNT1MS) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(CNT1MS - 1);

  logic              r_active;
  logic [TICK_W-1:0] r_tick;
  logic [MS_W-1:0]   r_ms_left;
  logic              w_tick_wrap;

  assign w_tick_wrap = (r_tick == TICK_LAST);
  assign o_expire    = r_active && w_tick_wrap && (r_ms_left <= MS_W'(1));

  // NOTE: async active-low reset in the sensitivity list; every
  // sequential assignment is non-blocking so all registers update together.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_active  <= 1'b0;
      r_tick    <= '0;
      r_ms_left <= '0;
    end else if (i_load) begin
      r_active  <= 1'b1;
      r_tick    <= '0;
      r_ms_left <= i_ms;
    end else if (r_active) begin
      if (o_expire) r_active <= 1'b0;
      if (w_tick_wrap) begin
        r_tick    <= '0;
        r_ms_left <= r_ms_left - MS_W'(1);
      end else begin
        r_tick <= r_tick + TICK_W'(1);
      end
    end
  end

endmodule

// File: rtl/lcd_bus_arbiter.sv
// Two-requester round-robin arbiter driving an HD44780-style LCD bus.
// Ports:
//   clk    - clock
//   reset  - asynchronous active-low reset
//   bus    - requester handshakes, done/busy status and LCD pins
// Each accepted write runs SETUP -> PULSE (lcd_e high) -> HOLD -> WAIT,
// then pulses done. lcd_rs/lcd_data stay latched until the next accept.
module lcd_bus_arbiter
  import lcd_pkg::*;
#(
  parameter int CNT1MS    = 100000,
  parameter int SETUP_CYC = 4,
  parameter int PULSE_CYC = 50,
  parameter int HOLD_CYC  = 4,
  parameter int EXEC_MS   = 1,
  parameter int CLEAR_MS  = 4
) (
  input  logic               clk,
  input  logic               reset,
  lcd_bus_arbiter_if.slave   bus
);

  localparam int MAX_MS = (CLEAR_MS > EXEC_MS) ? CLEAR_MS : EXEC_MS;
  localparam int MS_W   = $clog2(MAX_MS + 1);
  localparam logic [7:0] SETUP_LAST = 8'(SETUP_CYC - 1);
  localparam logic [7:0] PULSE_LAST = 8'(PULSE_CYC - 1);
  localparam logic [7:0] HOLD_LAST  = 8'(HOLD_CYC - 1);

  state_t          r_state;
  state_t          w_next;
  logic [7:0]      r_cyc;
  logic            r_prio;      // requester that wins a tie
  logic            r_id;        // requester owning the current write
  logic            r_ready0;
  logic            r_ready1;
  logic            r_done;
  logic            r_done_id;
  logic            r_lcd_e;
  logic            r_lcd_rs;
  logic [7:0]      r_lcd_data;
  logic            w_accept;
  logic            w_grant_id;
  logic            w_load;
  logic            w_expire;
  logic            w_finish;
  logic [MS_W-1:0] w_ms;

  assign w_ms = is_slow_cmd(r_lcd_rs, r_lcd_data) ? MS_W'(CLEAR_MS) : MS_W'(EXEC_MS);

  lcd_ms_timer #(
    .CNT1MS (CNT1MS),
    .MS_W   (MS_W)
  ) u_timer (
    .clk      (clk),
    .reset    (reset),
    .i_load   (w_load),
    .i_ms     (w_ms),
    .o_expire (w_expire)
  );

  // NOTE: every signal driven here gets a default first, so no path
  // through the case can leave one unassigned and infer a latch.
  always_comb begin
    w_next     = r_state;
    w_accept   = 1'b0;
    w_grant_id = 1'b0;
    w_load     = 1'b0;
    w_finish   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.req0_valid || bus.req1_valid) begin
          w_accept   = 1'b1;
          w_grant_id = (bus.req0_valid && bus.req1_valid) ? r_prio : bus.req1_valid;
          w_next     = ST_SETUP;
        end
      end
      ST_SETUP: if (r_cyc == SETUP_LAST) w_next = ST_PULSE;
      ST_PULSE: if (r_cyc == PULSE_LAST) w_next = ST_HOLD;
      ST_HOLD: begin
        if (r_cyc == HOLD_LAST) begin
          w_next = ST_WAIT;
          w_load = 1'b1;
        end
      end
      ST_WAIT: begin
        if (w_expire) begin
          w_next   = ST_IDLE;
          w_finish = 1'b1;
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_cyc   <= '0;
    end else begin
      r_state <= w_next;
      // Phase counter restarts on every state change; only SETUP/PULSE/HOLD use it.
      if ((w_next != r_state) || (r_state == ST_IDLE) || (r_state == ST_WAIT))
        r_cyc <= '0;
      else
        r_cyc <= r_cyc + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_prio     <= 1'b0;
      r_id       <= 1'b0;
      r_ready0   <= 1'b0;
      r_ready1   <= 1'b0;
      r_done     <= 1'b0;
      r_done_id  <= 1'b0;
      r_lcd_e    <= 1'b0;
      r_lcd_rs   <= 1'b0;
      r_lcd_data <= 8'h00;
    end else begin
      r_ready0 <= w_accept && !w_grant_id;
      r_ready1 <= w_accept && w_grant_id;
      r_done   <= w_finish;
      if (w_finish) r_done_id <= r_id;
      // Registered so lcd_e is glitch-free yet high exactly while in PULSE.
      r_lcd_e  <= (w_next == ST_PULSE);
      if (w_accept) begin
        r_id       <= w_grant_id;
        r_prio     <= ~w_grant_id;
        r_lcd_rs   <= w_grant_id ? bus.req1_rs   : bus.req0_rs;
        r_lcd_data <= w_grant_id ? bus.req1_data : bus.req0_data;
      end
    end
  end

  assign bus.req0_ready = r_ready0;
  assign bus.req1_ready = r_ready1;
  assign bus.done       = r_done;
  assign bus.done_id    = r_done_id;
  assign bus.busy       = (r_state != ST_IDLE);
  assign bus.lcd_e      = r_lcd_e;
  assign bus.lcd_rs     = r_lcd_rs;
  assign bus.lcd_rw     = 1'b0;
  assign bus.lcd_data   = r_lcd_data;

endmodule

// File: doc/lcd_bus_arbiter.md
LCD_BUS_ARBITER -- requirements
Module: lcd_bus_arbiter

Interface
REQ-001 SHALL have parameter CNT1MS, default 100000, clk cycles per 1 ms.
REQ-002 SHALL have parameter SETUP_CYC, default 4, cycles rs/data are stable before lcd_e rises (legal range 1..255).
REQ-003 SHALL have parameter PULSE_CYC, default 50, lcd_e high width in cycles (legal range 1..255).
REQ-004 SHALL have parameter HOLD_CYC, default 4, cycles rs/data are held after lcd_e falls (legal range 1..255).
REQ-005 SHALL have parameter EXEC_MS, default 1, post-write wait in ms for normal commands and data.
REQ-006 SHALL have parameter CLEAR_MS, default 4, post-write wait in ms for clear (0x01) and home (0x02) commands.
REQ-007 Ports SHALL be:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low.
- req0_valid  in  1  requester 0 (init sequencer) write request.
- req0_rs  in  1  requester 0 register select.
- req0_data  in  8  requester 0 byte.
- req0_ready  out  1  one-cycle accept pulse to requester 0.
- req1_valid  in  1  requester 1 (display refresh) write request.
- req1_rs  in  1  requester 1 register select.
- req1_data  in  8  requester 1 byte.
- req1_ready  out  1  one-cycle accept pulse to requester 1.
- done  out  1  one-cycle pulse when a write completes, including its wait.
- done_id  out  1  requester served by the current done pulse.
- busy  out  1  high whenever state is not IDLE.
- lcd_e  out  1  LCD enable.
- lcd_rs  out  1  LCD register select.
- lcd_rw  out  1  tied 0.
- lcd_data  out  8  LCD data bus.

Function
REQ-008 The FSM SHALL have states IDLE, SETUP, PULSE, HOLD and WAIT, with transitions IDLE->SETUP on accept, SETUP->PULSE after SETUP_CYC cycles, PULSE->HOLD after PULSE_CYC cycles, HOLD->WAIT after HOLD_CYC cycles, and WAIT->IDLE at wait expiry.
REQ-009 In IDLE with any valid high, the block SHALL grant one requester, latch its rs/data into lcd_rs/lcd_data, register reqN_ready high for exactly one cycle, and enter SETUP on the same edge.
REQ-010 Arbitration SHALL be round-robin: when both are valid, the requester not served last wins; after reset, requester 0 has priority.
REQ-011 Valid and rs/data SHALL be sampled only in IDLE; inputs are ignored in all other states; a requester dropping valid before ready SHALL NOT cause an error.
REQ-012 lcd_e SHALL be 1 only in PULSE; lcd_rs/lcd_data SHALL stay constant from accept until the next accept, holding their value through IDLE.
REQ-013 The WAIT length SHALL be CLEAR_MS*CNT1MS cycles if the latched rs=0 and data is 0x01 or 0x02, else EXEC_MS*CNT1MS cycles; the ms counter SHALL restart on WAIT entry (no free-running phase error).
REQ-014 done SHALL pulse, with done_id valid, on the cycle WAIT->IDLE; total latency from the sampling edge to done SHALL be SETUP_CYC+PULSE_CYC+HOLD_CYC+wait cycles.
REQ-015 Back-to-back: the earliest next accept SHALL be the cycle after done; no IDLE bubble beyond that one cycle.
REQ-016 Counters SHALL be wide enough for CLEAR_MS*CNT1MS without wrap.

Reset
REQ-017 Reset low SHALL asynchronously force state IDLE, lcd_e=0, lcd_rs=0, lcd_data=0x00, ready/done/done_id/busy=0, and the round-robin pointer to favour requester 0.
REQ-018 Reset mid-write SHALL abort the write immediately, with lcd_e dropping without waiting for HOLD; there SHALL be no done for the aborted write.

Structure
REQ-019 Package lcd_pkg SHALL hold the FSM state encoding and the command constants CMD_CLEAR=0x01 and CMD_HOME=0x02.
REQ-020 A sub-module lcd_ms_timer (load ms count, tick via CNT1MS, expire pulse) SHALL implement the WAIT timing.

Verification (CNT1MS=10, SETUP_CYC=2, PULSE_CYC=3, HOLD_CYC=2, EXEC_MS=1, CLEAR_MS=4)
REQ-021 req0 valid, rs=1, data=0x41 -> req0_ready one cycle; lcd_e high exactly 3 cycles starting 2 after accept; done with done_id=0 17 cycles after the sampling edge.
REQ-022 req0 rs=0, data=0x01 -> done 47 cycles after the sampling edge; rs=0, data=0x38 -> 17 cycles.
REQ-023 Both valid continuously after reset -> grants alternate 0,1,0,1; each accept is exactly one cycle after the previous done.
REQ-024 Requester data changes during PULSE -> lcd_data unchanged until the next accept.
REQ-025 Reset asserted in PULSE -> lcd_e=0 in the same cycle (asynchronously); all outputs at reset values; no done pulse; first grant after release goes to req0.
